alu_instr_sequencer: RTL
========================

# alu_instr_sequencer

Multi-cycle control sequencer for three-register ALU and two-register MUL/DIV instructions on the phase-1 bus datapath.
- Walks each instruction through fetch (T0–T2) and execute (T3–T5/T6), driving the datapath's control lines from a state register.
- Parametrised in IR width and register-file size.
- Adds a memory-ready handshake for instruction fetch, illegal-opcode detection and a done/busy status pair.
- Sits between the start/control logic and `Datapath`, replacing hand-driven control from benches.

## Interface
- `IR_WIDTH`, 32: instruction register width. Opcode occupies `[IR_WIDTH-1 -: 5]`.
- `REG_COUNT`, 16: general registers; `RA_W = $clog2(REG_COUNT)`.
- Register fields sit directly below the opcode, in the order Ra, Rb, Rc, each `RA_W` bits.

- `Clock` in 1: single clock; all state changes on the rising edge.
- `clear` in 1: synchronous, active-high reset.
- `start` in 1: begin an instruction; sampled in IDLE only.
- `mem_ready` in 1: memory read data valid; sampled in T1.
- `ir` in IR_WIDTH: datapath IR contents, valid from T3 onward.
- `PCout`, `PCin`, `IncPC`, `MARin`, `Read`, `MDRin`, `MDRout`, `IRin`, `Yin`, `Zin`, `Zlowout`, `Zhighout`, `HIin`, `LOin` out 1 each: datapath strobes.
- `Rout` out REG_COUNT: one-hot register-out select.
- `Rin` out REG_COUNT: one-hot register-in select.
- `alu_op` out 5: ALU operation code; 0 outside T4.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse in the final execute state.
- `illegal` out 1: one-cycle pulse when an unsupported opcode is decoded.

## Operation
- Opcodes supported:
  - add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010.
  - mul 01111, div 10000 (only with `MULDIV_EN`).
- States: IDLE, T0, T1, T2, T3, T4, T5, T6. Moore outputs decoded from the state register plus `ir` fields.
- IDLE: all outputs 0.
  - `start`=1 → T0.
- T0: PCout, MARin, IncPC, Zin.
  - Unconditional → T1.
- T1: Zlowout, PCin, Read, MDRin.
  - `mem_ready`=0 → stay in T1 with outputs held. Re-loading PC from unchanged Z is harmless.
  - `mem_ready`=1 → T2.
- T2: MDRout, IRin.
  - Unconditional → T3.
- T3: decode `ir` opcode.
  - Illegal opcode: all strobes 0, `illegal`=1 → IDLE.
  - Three-register ops: Rout[Rb], Yin.
  - mul/div: Rout[Ra], Yin.
- T4: Zin, `alu_op`=opcode.
  - Three-register ops: Rout[Rc].
  - mul/div: Rout[Rb].
- T5:
  - Three-register ops: Zlowout, Rin[Ra], `done`=1 → IDLE.
  - mul/div: Zlowout, LOin → T6.
- T6: Zhighout, HIin, `done`=1 → IDLE.
- Register fields ≥ REG_COUNT cannot occur (field width = RA_W). Ra=Rb=Rc is legal.
- `start` outside IDLE is ignored; no queuing.

## Timing
- Reset: `clear`=1 at an edge → IDLE next cycle, every output 0. Applies mid-instruction in any state, including a T1 stall.
- Output timing: outputs change one cycle after the state transition that selects them. No combinational path from `start` or `mem_ready` to any output.
- Latency from the `start` edge to the `done` pulse, `mem_ready` tied high:
  - Three-register ops: 6 cycles (T0–T5).
  - mul/div: 7 cycles (T0–T6).
- Each cycle `mem_ready` is low in T1 adds one cycle.
- Back-to-back instructions: `start` high in the IDLE cycle after `done` begins the next instruction. Minimum gap is one IDLE cycle.
- At most one bit of `Rout` and one bit of `Rin` is set in any cycle.

## Configuration
- `ALU_SEQ_MULDIV_EN` defined:
  - mul/div decode legal; T6 present.
  - T5 drives LOin; T6 drives HIin.
- Undefined:
  - 01111 and 10000 decode as illegal.
  - T6 is not synthesised; HIin, LOin and Zhighout are tied 0.

## Test plan
- Add, `ir`=0x18918000 (add R1,R2,R3), `mem_ready`=1, `start` pulse:
  - T3 Rout=0x0004 + Yin.
  - T4 Rout=0x0008 + Zin + alu_op=00011.
  - T5 Rin=0x0002 + Zlowout + done.
  - Total 6 cycles; then IDLE.
- Fetch stall: `mem_ready` low for 3 cycles in T1 → Read/MDRin/PCin held 4 cycles, done at cycle 9, T2 entered exactly once.
- Mul with `ALU_SEQ_MULDIV_EN`, `ir`=0x7A280000 (mul R4,R5):
  - T3 Rout=0x0010.
  - T4 Rout=0x0020, alu_op=01111.
  - T5 LOin.
  - T6 HIin + Zhighout + done.
  - Total 7 cycles.
- Illegal opcode, `ir`=0xF8000000 → `illegal` pulses in T3, `done` stays 0, IDLE next cycle, Rout/Rin never set.
- Reset mid-op: `clear` asserted in T4 → next cycle all outputs 0, busy=0; a new `start` completes normally.
- `start` held high continuously → a new instruction begins each time IDLE is entered, with exactly one `done` per instruction.

Source files
------------

// File: rtl/alu_instr_sequencer.sv
// alu_instr_sequencer: multi-cycle control sequencer for three-register ALU
// and two-register MUL/DIV instructions on the phase-1 bus datapath.
// Fetch runs T0..T2 with a memory-ready stall in T1; execute runs T3..T5
// (T6 for mul/div). Outputs are Moore, decoded from the state register and
// the ir fields only, so start and mem_ready never reach an output directly.
// Optional feature macro: ALU_SEQ_MULDIV_EN enables mul/div decode and T6.
module alu_instr_sequencer #(
    parameter int IR_WIDTH  = 32,
    parameter int REG_COUNT = 16
) (
    input  logic                 Clock,
    input  logic                 clear,
    input  logic                 start,
    input  logic                 mem_ready,
    input  logic [IR_WIDTH-1:0]  ir,
    output logic                 PCout,
    output logic                 PCin,
    output logic                 IncPC,
    output logic                 MARin,
    output logic                 Read,
    output logic                 MDRin,
    output logic                 MDRout,
    output logic                 IRin,
    output logic                 Yin,
    output logic                 Zin,
    output logic                 Zlowout,
    output logic                 Zhighout,
    output logic                 HIin,
    output logic                 LOin,
    output logic [REG_COUNT-1:0] Rout,
    output logic [REG_COUNT-1:0] Rin,
    output logic [4:0]           alu_op,
    output logic                 busy,
    output logic                 done,
    output logic                 illegal
);

    localparam int RA_W = $clog2(REG_COUNT);

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_OR  = 5'b01010;
`ifdef ALU_SEQ_MULDIV_EN
    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;
`endif

`ifdef ALU_SEQ_MULDIV_EN
    typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_e;
`else
    typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5} state_e;
`endif

    state_e state, state_nxt;

    logic [4:0]      opcode;
    logic [RA_W-1:0] ra, rb, rc;
    logic            is_alu3;
    logic            is_legal;
    logic            unused_ir;

    assign opcode = ir[IR_WIDTH-1 -: 5];
    assign ra     = ir[IR_WIDTH-6 -: RA_W];
    assign rb     = ir[IR_WIDTH-6-RA_W -: RA_W];
    assign rc     = ir[IR_WIDTH-6-2*RA_W -: RA_W];
    // Low ir bits carry no meaning for this sequencer.
    assign unused_ir = ^ir;

    // The eight three-register opcodes form one contiguous range add..or.
    assign is_alu3 = (opcode >= OP_ADD) && (opcode <= OP_OR);

`ifdef ALU_SEQ_MULDIV_EN
    logic is_muldiv;
    assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
    assign is_legal  = is_alu3 || is_muldiv;
`else
    assign is_legal  = is_alu3;
    assign HIin      = 1'b0;
    assign LOin      = 1'b0;
    assign Zhighout  = 1'b0;
`endif

    function automatic logic [REG_COUNT-1:0] onehot(input logic [RA_W-1:0] idx);
        logic [REG_COUNT-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // State register with synchronous clear.
    always_ff @(posedge Clock) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = T0;
            T0:   state_nxt = T1;
            T1:   if (mem_ready) state_nxt = T2;
            T2:   state_nxt = T3;
            T3:   state_nxt = is_legal ? T4 : IDLE;
            T4:   state_nxt = T5;
`ifdef ALU_SEQ_MULDIV_EN
            T5:   state_nxt = is_muldiv ? T6 : IDLE;
            T6:   state_nxt = IDLE;
`else
            T5:   state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Moore output decode from state and ir fields.
    always_comb begin
        PCout   = 1'b0;
        PCin    = 1'b0;
        IncPC   = 1'b0;
        MARin   = 1'b0;
        Read    = 1'b0;
        MDRin   = 1'b0;
        MDRout  = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        Zin     = 1'b0;
        Zlowout = 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
        Zhighout = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
`endif
        Rout    = '0;
        Rin     = '0;
        alu_op  = '0;
        busy    = (state != IDLE);
        done    = 1'b0;
        illegal = 1'b0;
        unique case (state)
            IDLE: ;
            T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            T3: begin
                if (is_alu3) begin
                    Rout = onehot(rb);
                    Yin  = 1'b1;
`ifdef ALU_SEQ_MULDIV_EN
                end else if (is_muldiv) begin
                    Rout = onehot(ra);
                    Yin  = 1'b1;
`endif
                end else begin
                    illegal = 1'b1;
                end
            end
            T4: begin
                Zin    = 1'b1;
                alu_op = opcode;
`ifdef ALU_SEQ_MULDIV_EN
                Rout   = is_muldiv ? onehot(rb) : onehot(rc);
`else
                Rout   = onehot(rc);
`endif
            end
            T5: begin
                Zlowout = 1'b1;
`ifdef ALU_SEQ_MULDIV_EN
                if (is_muldiv) begin
                    LOin = 1'b1;
                end else begin
                    Rin  = onehot(ra);
                    done = 1'b1;
                end
`else
                Rin  = onehot(ra);
                done = 1'b1;
`endif
            end
`ifdef ALU_SEQ_MULDIV_EN
            T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                done     = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule
